wb_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback logic. Closes the register-file loop
//  by driving writeback_control/rd_w/writeback_data into the decode stage's

---
 rtl/wb_stage.sv | 128 ++++++++++++
 tb/tb_wb_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback logic: captures the MEM-stage slot,
// extracts load data, selects the writeback result, drives the register-file
// write port and counts retired instructions.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic             valid_m,
    input  logic             regwrite_m,
    input  logic [1:0]       result_src_m,
    input  logic [2:0]       funct3_m,
    input  logic [4:0]       rd_m,
    input  logic [XLEN-1:0]  alu_result_m,
    input  logic [XLEN-1:0]  read_data_m,
    input  logic [XLEN-1:0]  pc_plus_4_m,
    output logic             writeback_control,
    output logic [4:0]       rd_w,
    output logic [XLEN-1:0]  writeback_data,
    output logic             valid_w,
    output logic [CNT_W-1:0] instret
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             valid_q;
    logic             regwrite_q;
    logic [1:0]       result_src_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  alu_result_q;
    logic [XLEN-1:0]  read_data_q;
    logic [XLEN-1:0]  pc_plus_4_q;
    logic [CNT_W-1:0] instret_q;

    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  result;

    // MEM/WB register: flush beats stall beats load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            result_src_q <= 2'b00;
            funct3_q     <= 3'b000;
            rd_q         <= 5'd0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus_4_q  <= '0;
        end else if (flush_w) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            result_src_q <= 2'b00;
            funct3_q     <= 3'b000;
            rd_q         <= 5'd0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus_4_q  <= '0;
        end else if (!stall_w) begin
            valid_q      <= valid_m;
            regwrite_q   <= regwrite_m & valid_m;
            result_src_q <= result_src_m;
            funct3_q     <= funct3_m;
            rd_q         <= rd_m;
            alu_result_q <= alu_result_m;
            read_data_q  <= read_data_m;
            pc_plus_4_q  <= pc_plus_4_m;
        end
    end

    // Retire counter: the WB entry retires on the edge where it advances unflushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else if (valid_q && !stall_w && !flush_w) begin
            instret_q <= instret_q + CntOne;
        end
    end

    // Load extraction: little-endian byte/half pick by address offset, then extend.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = read_data_q;
        unique case (alu_result_q[1:0])
            2'd0: byte_sel = read_data_q[7:0];
            2'd1: byte_sel = read_data_q[15:8];
            2'd2: byte_sel = read_data_q[23:16];
            2'd3: byte_sel = read_data_q[31:24];
            default: byte_sel = 8'h00;
        endcase
        // Misaligned halfwords are not trapped; off[0] is simply ignored.
        half_sel = alu_result_q[1] ? read_data_q[31:16] : read_data_q[15:0];
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = read_data_q;
        endcase
    end

    // Writeback result select; the reserved encoding yields zero.
    always_comb begin
        result = '0;
        unique case (result_src_q)
            2'b00:   result = alu_result_q;
            2'b01:   result = load_data;
            2'b10:   result = pc_plus_4_q;
            default: result = '0;
        endcase
    end

    // Outputs come only from the MEM/WB register; x0 is never written.
    always_comb begin
        writeback_control = regwrite_q & valid_q & (rd_q != 5'd0);
        rd_w              = rd_q;
        writeback_data    = result;
        valid_w           = valid_q;
        instret           = instret_q;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writeback entries,
// a negedge monitor pops and compares them and tracks the retire count.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_w = 1'b0;
    logic        flush_w = 1'b0;
    logic        valid_m = 1'b0;
    logic        regwrite_m = 1'b0;
    logic [1:0]  result_src_m = 2'b00;
    logic [2:0]  funct3_m = 3'b000;
    logic [4:0]  rd_m = 5'd0;
    logic [31:0] alu_result_m = 32'h0;
    logic [31:0] read_data_m = 32'h0;
    logic [31:0] pc_plus_4_m = 32'h0;

    logic        writeback_control, valid_w;
    logic [4:0]  rd_w;
    logic [31:0] writeback_data;
    logic [63:0] instret;

    // Narrow-counter copy so wrap-around is exercised many times.
    logic        wc_s, valid_s;
    logic [4:0]  rd_s;
    logic [31:0] data_s;
    logic [2:0]  instret_s;

    wb_stage dut (
        .clk(clk), .reset_n(reset_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .result_src_m(result_src_m),
        .funct3_m(funct3_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
        .read_data_m(read_data_m), .pc_plus_4_m(pc_plus_4_m),
        .writeback_control(writeback_control), .rd_w(rd_w),
        .writeback_data(writeback_data), .valid_w(valid_w), .instret(instret)
    );

    wb_stage #(.XLEN(32), .CNT_W(3)) dut_s (
        .clk(clk), .reset_n(reset_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .result_src_m(result_src_m),
        .funct3_m(funct3_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
        .read_data_m(read_data_m), .pc_plus_4_m(pc_plus_4_m),
        .writeback_control(wc_s), .rd_w(rd_s),
        .writeback_data(data_s), .valid_w(valid_s), .instret(instret_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    longint unsigned exp_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference result straight from the instruction-set rules.
    function automatic logic [31:0] ref_wb(input logic [1:0] src, input logic [2:0] f3,
                                           input logic [31:0] alu, input logic [31:0] rdat,
                                           input logic [31:0] pc4);
        int unsigned b, h, w;
        w = rdat;
        b = (w >> (8 * alu[1:0])) & 32'hFF;
        h = (w >> (16 * alu[1])) & 32'hFFFF;
        case (src)
            2'd0: return alu;
            2'd2: return pc4;
            2'd3: return 32'h0;
            default: begin
                case (f3)
                    3'b000:  return (b >= 128) ? b - 256 : b;
                    3'b100:  return b;
                    3'b001:  return (h >= 32768) ? h - 65536 : h;
                    3'b101:  return h;
                    default: return w;
                endcase
            end
        endcase
    endfunction

    // Apply one cycle of inputs; once the edge has captured them, log what WB should show.
    task automatic step(input logic st, input logic fl, input logic vm, input logic rw,
                        input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc4);
        exp_t e;
        stall_w = st; flush_w = fl; valid_m = vm; regwrite_m = rw;
        result_src_m = src; funct3_m = f3; rd_m = rd;
        alu_result_m = alu; read_data_m = rdat; pc_plus_4_m = pc4;
        @(posedge clk);
        #1;
        if (!fl && !st && vm) begin
            e.wc = rw && (rd != 5'd0);
            e.rd = rd;
            e.data = ref_wb(src, f3, alu, rdat, pc4);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wc", {63'b0, writeback_control}, 64'd0);
        chk("rst_rd", {59'b0, rd_w}, 64'd0);
        chk("rst_data", {32'b0, writeback_data}, 64'd0);
        chk("rst_valid", {63'b0, valid_w}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_instret_s", {61'b0, instret_s}, 64'd0);
        exp_q.delete();
        exp_cnt = 0;
        stall_w = 1'b0; flush_w = 1'b0; valid_m = 1'b0; regwrite_m = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wc", {63'b0, writeback_control}, 64'd0);
        mon_en = 1'b1;
    endtask

    // Monitor: compare the WB slot against the scoreboard and track retirements.
    always @(negedge clk) begin
        if (mon_en) begin
            bit ev;
            ev = (exp_q.size() != 0);
            chk("instret", instret, exp_cnt);
            chk("instret_wrap", {61'b0, instret_s}, exp_cnt & 64'd7);
            chk("valid_w", {63'b0, valid_w}, {63'b0, ev});
            chk("valid_w_s", {63'b0, valid_s}, {63'b0, ev});
            if (ev) begin
                chk("wc", {63'b0, writeback_control}, {63'b0, exp_q[0].wc});
                chk("rd_w", {59'b0, rd_w}, {59'b0, exp_q[0].rd});
                chk("wb_data", {32'b0, writeback_data}, {32'b0, exp_q[0].data});
                chk("wb_data_s", {32'b0, data_s}, {32'b0, exp_q[0].data});
                if (!stall_w && !flush_w) exp_cnt++;
                if (!stall_w || flush_w) exp_q.delete(0);
            end else begin
                chk("bubble_wc", {63'b0, writeback_control}, 64'd0);
                chk("bubble_wc_s", {63'b0, wc_s}, 64'd0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("init_wc", {63'b0, writeback_control}, 64'd0);
        mon_en = 1'b1;
        idle();

        // ALU writeback to x5
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 5'd5, 32'h1234, 32'h0, 32'h0);
        idle();
        idle();

        // Load extraction on 32'h80FF7F01
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b000, 5'd6, 32'h3, 32'h80FF7F01, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b100, 5'd7, 32'h3, 32'h80FF7F01, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b001, 5'd8, 32'h2, 32'h80FF7F01, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b101, 5'd9, 32'h0, 32'h80FF7F01, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 3'b010, 5'd10, 32'h1, 32'h80FF7F01, 32'h0);

        // x0 write suppressed, then JAL link, then reserved select
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd0, 32'hDEAD, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 32'h55, 32'h0, 32'h104);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 3'b000, 5'd2, 32'h55, 32'h1, 32'h104);

        // Three-cycle stall holds the entry, then stall+flush drops it uncounted
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd12, 32'hCAFE, 32'h0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd13, 32'h1, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 5'd14, 32'h2, 32'h0, 32'h0);
        idle();
        chk("flush_valid", {63'b0, valid_w}, 64'd0);

        // Reset while an entry is held by a stall
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h77, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 32'h88, 32'h0, 32'h0);
        do_reset();
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic st, fl, vm, rw;
            logic [4:0] rd;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            vm = ($urandom_range(0, 3) != 0);
            rw = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(st, fl, vm, rw, 2'($urandom), 3'($urandom), rd,
                 $urandom, $urandom, $urandom);
            if (i == 200) do_reset();
        end
        idle();
        idle();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
